mips_multicycle_ctrl: RTL and testbench



---
 rtl/mips_multicycle_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback and drives the ALU and datapath controls.
// Optional build macro MIPS_CTRL_BNE_EN adds bne sharing the beq execute state with an inverted zero sense.
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_RTYPEEX = 4'd6;
  localparam logic [3:0] S_RTYPEWB = 4'd7;
  localparam logic [3:0] S_BEQEX   = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JEX     = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MIPS_CTRL_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [3:0] state_q, state_d;
  logic       illegal_q, illegal_d;
  logic       op_legal, fn_legal;
  logic [2:0] fn_alu_op;
  logic       branch_taken;

  always_comb begin
    op_legal = 1'b0;
    case (opcode)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
`ifdef MIPS_CTRL_BNE_EN
      OP_BNE: op_legal = 1'b1;
`endif
      default: op_legal = 1'b0;
    endcase
  end

  // Unsupported funct still executes as ADD so the writeback state stays uniform.
  always_comb begin
    fn_legal  = 1'b1;
    fn_alu_op = ALU_ADD;
    case (funct)
      6'b100000: fn_alu_op = ALU_ADD;
      6'b100010: fn_alu_op = ALU_SUB;
      6'b100100: fn_alu_op = ALU_AND;
      6'b100101: fn_alu_op = ALU_OR;
      6'b101010: fn_alu_op = ALU_SLT;
      default:   fn_legal  = 1'b0;
    endcase
  end

`ifdef MIPS_CTRL_BNE_EN
  // Branch sense captured in DECODE: 1 means branch on not-equal.
  logic bne_q;
  always_ff @(posedge clk) begin
    if (rst) bne_q <= 1'b0;
    else if (state_q == S_DECODE) bne_q <= (opcode == OP_BNE);
  end
  assign branch_taken = zero ^ bne_q;
`else
  assign branch_taken = zero;
`endif

  assign illegal_d = ((state_q == S_DECODE) && !op_legal) ||
                     ((state_q == S_RTYPEEX) && !fn_legal);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
`ifdef MIPS_CTRL_BNE_EN
          OP_BNE:       state_d = S_BEQEX;
`endif
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = S_MEMWB;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  // During reset the outputs show FETCH values with every write enable held low.
  always_comb begin
    alu_op     = 3'b000;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    case (rst ? S_FETCH : state_q)
      S_FETCH: begin
        ir_write  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = ALU_ADD;
        pc_en     = 1'b1;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALU_ADD;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_RTYPEEX: begin
        alu_src_a = 1'b1;
        alu_op    = fn_alu_op;
      end
      S_RTYPEWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BEQEX: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = 2'b01;
        pc_en     = branch_taken;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_JEX: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      pc_en     = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign illegal = illegal_q;
  assign state   = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: per-instruction state lists and output tables predict every cycle's outputs.
module tb_mips_multicycle_ctrl;

  localparam int W = 20;

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] alu_op;
    logic       src_a;
    logic [1:0] src_b;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal;
  } ov_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic [2:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, illegal;
  logic [3:0] state;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .pc_en(pc_en), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .illegal(illegal), .state(state)
  );

  // clock / reset
  always #5 clk = ~clk;

  ov_t act;
  assign act = {state, alu_op, alu_src_a, alu_src_b, pc_src, pc_en, iord, mem_write,
                ir_write, reg_dst, mem_to_reg, reg_write, illegal};

  logic [W-1:0] exp_q[$];
  ov_t          snap[$];
  int           checks = 0;
  int           errors = 0;
  logic         pend = 1'b0;
  ov_t          cmp_e;

  // model
  function automatic logic is_bne(input logic [5:0] op);
`ifdef MIPS_CTRL_BNE_EN
    return op == 6'b000101;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic is_legal_op(input logic [5:0] op);
    return op == 6'b100011 || op == 6'b101011 || op == 6'b000000 || op == 6'b000100 ||
           op == 6'b001000 || op == 6'b000010 || is_bne(op);
  endfunction

  function automatic logic is_bad_fn(input logic [5:0] fn);
    return !(fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
             fn == 6'b100101 || fn == 6'b101010);
  endfunction

  function automatic logic [W-1:0] exp_vec(input int st, input logic [5:0] op, input logic [5:0] fn,
                                           input logic z, input logic ill, input logic in_rst);
    ov_t v;
    int  eff;
    v = '0;
    v.st = st[3:0];
    v.illegal = ill;
    eff = in_rst ? 0 : st;
    case (eff)
      0:  begin v.ir_write = 1; v.src_b = 2'b01; v.alu_op = 3'b010; v.pc_en = 1; end
      1:  begin v.src_b = 2'b11; v.alu_op = 3'b010; end
      2:  begin v.src_a = 1; v.src_b = 2'b10; v.alu_op = 3'b010; end
      3:  v.iord = 1;
      4:  begin v.mem_to_reg = 1; v.reg_write = 1; end
      5:  begin v.iord = 1; v.mem_write = 1; end
      6:  begin
        v.src_a = 1;
        case (fn)
          6'b100010: v.alu_op = 3'b110;
          6'b100100: v.alu_op = 3'b000;
          6'b100101: v.alu_op = 3'b001;
          6'b101010: v.alu_op = 3'b111;
          default:   v.alu_op = 3'b010;
        endcase
      end
      7:  begin v.reg_dst = 1; v.reg_write = 1; end
      8:  begin v.src_a = 1; v.alu_op = 3'b110; v.pc_src = 2'b01; v.pc_en = is_bne(op) ? ~z : z; end
      9:  begin v.src_a = 1; v.src_b = 2'b10; v.alu_op = 3'b010; end
      10: v.reg_write = 1;
      11: begin v.pc_src = 2'b10; v.pc_en = 1; end
      default: ;
    endcase
    if (in_rst) begin
      v.pc_en = 0; v.mem_write = 0; v.ir_write = 0; v.reg_write = 0;
    end
    return v;
  endfunction

  // scoreboard
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cmp_e = exp_q.pop_front();
      checks++;
      if (act !== cmp_e) begin
        errors++;
        $display("FAIL outputs t=%0t state=%0d actual=%05h required=%05h (req state %0d)",
                 $time, state, act, cmp_e, cmp_e.st);
      end
    end
  end

  task automatic lit(input string name, input logic [3:0] act_v, input logic [3:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act_v, exp_v);
    end
  endtask

  // driver: called at posedge+1 with the DUT in FETCH
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z, input int rst_idx);
    int sts[$];
    logic [W-1:0] v;
    snap = {};
    opcode = op; funct = fn; zero = z;
    if (!is_legal_op(op)) sts = {0, 1};
    else if (is_bne(op)) sts = {0, 1, 8};
    else begin
      case (op)
        6'b100011: sts = {0, 1, 2, 3, 4};
        6'b101011: sts = {0, 1, 2, 5};
        6'b000000: sts = {0, 1, 6, 7};
        6'b000100: sts = {0, 1, 8};
        6'b001000: sts = {0, 1, 9, 10};
        default:   sts = {0, 1, 11};
      endcase
    end
    for (int k = 0; k < sts.size(); k++) begin
      if (k == rst_idx) begin
        rst = 1'b1;
        v = exp_vec(sts[k], op, fn, z, pend, 1'b1);
        pend = 1'b0;
      end else begin
        v = exp_vec(sts[k], op, fn, z, pend, 1'b0);
        pend = (sts[k] == 1 && !is_legal_op(op)) || (sts[k] == 6 && is_bad_fn(fn));
      end
      exp_q.push_back(v);
      @(negedge clk);
      snap.push_back(act);
      @(posedge clk); #1;
      if (k == rst_idx) begin
        rst = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      exp_q.push_back(exp_vec(0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b1));
      @(negedge clk);
      lit("rst_state", state, 4'd0);
      lit("rst_enables", {pc_en, ir_write, reg_write, mem_write}, 4'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    run_instr(6'b100011, 6'd0, 1'($urandom_range(0, 1)), -1);
    lit("first_pc_en", snap[0].pc_en, 4'd1);
    lit("first_ir_write", snap[0].ir_write, 4'd1);
    lit("first_alu_op", snap[0].alu_op, 4'd2);
    lit("lw_state4", snap[4].st, 4'd4);
    lit("lw_m2r", snap[4].mem_to_reg, 4'd1);
    lit("lw_rw", snap[4].reg_write, 4'd1);
    lit("lw_iord_s3", snap[3].iord, 4'd1);

    run_instr(6'b101011, 6'd0, 1'($urandom_range(0, 1)), -1);
    lit("sw_mem_write", snap[3].mem_write, 4'd1);

    run_instr(6'b000000, 6'b101010, 1'b0, -1);
    lit("slt_alu_op", snap[2].alu_op, 4'd7);
    run_instr(6'b000000, 6'b100010, 1'b1, -1);
    lit("sub_alu_op", snap[2].alu_op, 4'd6);
    lit("rtype_reg_dst", snap[3].reg_dst, 4'd1);
    run_instr(6'b000000, 6'b100000, 1'b0, -1);
    run_instr(6'b000000, 6'b100100, 1'b0, -1);
    run_instr(6'b000000, 6'b100101, 1'b1, -1);

    run_instr(6'b000100, 6'd0, 1'b1, -1);
    lit("beq_taken_pc_en", snap[2].pc_en, 4'd1);
    lit("beq_pc_src", snap[2].pc_src, 4'd1);
    run_instr(6'b000100, 6'd0, 1'b0, -1);
    lit("beq_not_taken", snap[2].pc_en, 4'd0);

    run_instr(6'b000101, 6'd0, 1'b1, -1);
`ifdef MIPS_CTRL_BNE_EN
    lit("bne_z1_pc_en", snap[2].pc_en, 4'd0);
    run_instr(6'b000101, 6'd0, 1'b0, -1);
    lit("bne_z0_pc_en", snap[2].pc_en, 4'd1);
    run_instr(6'b000010, 6'd0, 1'b0, -1);
`else
    run_instr(6'b000010, 6'd0, 1'b0, -1);
    lit("bne_illegal_pulse", snap[0].illegal, 4'd1);
`endif

    run_instr(6'b001000, 6'd0, 1'($urandom_range(0, 1)), -1);
    run_instr(6'b000010, 6'd0, 1'b1, -1);
    lit("j_pc_src", snap[2].pc_src, 4'd2);

    run_instr(6'b111111, 6'd0, 1'b0, -1);
    lit("bad_op_decode_back", snap[1].st, 4'd1);
    run_instr(6'b000000, 6'b000111, 1'b0, -1);
    lit("bad_op_pulse", snap[0].illegal, 4'd1);
    lit("bad_op_pulse_once", snap[1].illegal, 4'd0);
    lit("bad_fn_alu_op", snap[2].alu_op, 4'd2);
    lit("bad_fn_pulse", snap[3].illegal, 4'd1);
    run_instr(6'b000010, 6'd0, 1'b0, -1);
    lit("bad_fn_pulse_once", snap[0].illegal, 4'd0);

    run_instr(6'b100011, 6'd0, 1'b0, 3);
    lit("rst_memrd_rw", snap[3].reg_write, 4'd0);
    run_instr(6'b001000, 6'd0, 1'b0, -1);
    lit("after_rst_state", snap[0].st, 4'd0);
    lit("after_rst_addiwb", snap[3].reg_write, 4'd1);

    @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
